// File: rtl/cdb_arbiter.sv
// Rotating-priority arbiter sharing NUM_PORTS CDB/ROB completion ports among
// NUM_REQ FU result requesters, with a one-cycle registered completion stage.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int ROBN_W    = 5,
  parameter int PRN_W     = 6,
  parameter int XLEN      = 32,
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ROBN_W-1:0]   req_robn,
  input  logic [NUM_REQ*PRN_W-1:0]    req_prn,
  input  logic [NUM_REQ*XLEN-1:0]     req_data,
  input  logic [NUM_REQ-1:0]          req_taken,
  input  logic [NUM_REQ*XLEN-1:0]     req_target,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]        cdb_valid,
  output logic [NUM_PORTS*ROBN_W-1:0] cdb_robn,
  output logic [NUM_PORTS*PRN_W-1:0]  cdb_prn,
  output logic [NUM_PORTS*XLEN-1:0]   cdb_data,
  output logic [NUM_PORTS-1:0]        cdb_taken,
  output logic [NUM_PORTS*XLEN-1:0]   cdb_target,
  output logic [PTR_W-1:0]            prio_ptr
);

  logic [PTR_W-1:0]            r_ptr;
  logic [NUM_PORTS-1:0]        r_cdb_valid;
  logic [NUM_PORTS*ROBN_W-1:0] r_cdb_robn;
  logic [NUM_PORTS*PRN_W-1:0]  r_cdb_prn;
  logic [NUM_PORTS*XLEN-1:0]   r_cdb_data;
  logic [NUM_PORTS-1:0]        r_cdb_taken;
  logic [NUM_PORTS*XLEN-1:0]   r_cdb_target;

  logic [NUM_REQ-1:0]          w_grant;
  logic [PTR_W-1:0]            w_last;
  logic [PTR_W:0]              w_sum;
  logic [PTR_W-1:0]            w_idx;
  int unsigned                 w_rank;
  logic                        w_hs;
  logic [NUM_PORTS-1:0]        w_nxt_valid;
  logic [NUM_PORTS*ROBN_W-1:0] w_nxt_robn;
  logic [NUM_PORTS*PRN_W-1:0]  w_nxt_prn;
  logic [NUM_PORTS*XLEN-1:0]   w_nxt_data;
  logic [NUM_PORTS-1:0]        w_nxt_taken;
  logic [NUM_PORTS*XLEN-1:0]   w_nxt_target;

  // Walk the ring once from r_ptr; the k-th valid requester found owns port k.
  // Squash suppresses every grant, so unused/squashed ports load zeros.
  always_comb begin
    w_grant      = '0;
    w_last       = r_ptr;
    w_sum        = '0;
    w_idx        = '0;
    w_rank       = 0;
    w_nxt_valid  = '0;
    w_nxt_robn   = '0;
    w_nxt_prn    = '0;
    w_nxt_data   = '0;
    w_nxt_taken  = '0;
    w_nxt_target = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(j);
      if (w_sum >= (PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (req_valid[w_idx] && !squash && (w_rank < NUM_PORTS)) begin
        w_grant[w_idx] = 1'b1;
        w_last         = w_idx;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          if (w_rank == k) begin
            w_nxt_valid[k]                    = 1'b1;
            w_nxt_robn[k*ROBN_W +: ROBN_W]    = req_robn[int'(w_idx)*ROBN_W +: ROBN_W];
            w_nxt_prn[k*PRN_W +: PRN_W]       = req_prn[int'(w_idx)*PRN_W +: PRN_W];
            w_nxt_data[k*XLEN +: XLEN]        = req_data[int'(w_idx)*XLEN +: XLEN];
            w_nxt_taken[k]                    = req_taken[w_idx];
            w_nxt_target[k*XLEN +: XLEN]      = req_target[int'(w_idx)*XLEN +: XLEN];
          end
        end
        w_rank = w_rank + 1;
      end
    end
  end

  assign w_hs      = |w_grant;
  assign req_ready = w_grant & {NUM_REQ{~reset}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_cdb_valid  <= '0;
      r_cdb_robn   <= '0;
      r_cdb_prn    <= '0;
      r_cdb_data   <= '0;
      r_cdb_taken  <= '0;
      r_cdb_target <= '0;
    end else begin
      r_cdb_valid  <= w_nxt_valid;
      r_cdb_robn   <= w_nxt_robn;
      r_cdb_prn    <= w_nxt_prn;
      r_cdb_data   <= w_nxt_data;
      r_cdb_taken  <= w_nxt_taken;
      r_cdb_target <= w_nxt_target;
      if (w_hs) begin
        if (w_last == PTR_W'(NUM_REQ - 1))
          r_ptr <= '0;
        else
          r_ptr <= w_last + 1'b1;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_robn   = r_cdb_robn;
  assign cdb_prn    = r_cdb_prn;
  assign cdb_data   = r_cdb_data;
  assign cdb_taken  = r_cdb_taken;
  assign cdb_target = r_cdb_target;
  assign prio_ptr   = r_ptr;

endmodule
